// File: rtl/qam4_frame_pack_ctrl.sv
// Frame controller after the 4QAM demodulator: frames the symbol stream, drops the
// pilot, packs 2-bit symbols LSB-first into bytes and buffers them in an FWFT FIFO.
module qam4_frame_pack_ctrl #(
  parameter int SYMS_PER_FRAME = 64,
  parameter bit PILOT_EN       = 1'b1,
  parameter int PILOT_IDX      = 36,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       FrameStart,
  input  logic       QAMDemodDataValid,
  input  logic [4:0] QAMDemodData,
  output logic       ByteValid,
  output logic [7:0] ByteData,
  output logic       ByteLast,
  input  logic       ByteReady,
  output logic       FrameDone,
  output logic       FrameAbort,
  output logic       Overflow,
  output logic       Busy
);
  localparam int CNT_W = $clog2(SYMS_PER_FRAME);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(SYMS_PER_FRAME - 1);
  localparam logic [CNT_W-1:0] PILOT_POS = CNT_W'(PILOT_IDX);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] sym_cnt, sym_cnt_nxt, sym_idx;
  logic [5:0]       pack_data, pack_data_nxt, base_data;  // at most 3 symbols are ever held
  logic [1:0]       pack_cnt, pack_cnt_nxt, base_cnt;
  logic [7:0]       merged;
  logic             accept, is_last, payload, push, push_last;

  logic [8:0]       mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [8:0]       head;
  logic             fifo_empty, fifo_full, pop, wr_en;

  logic unused_sym_bits;
  assign unused_sym_bits = ^QAMDemodData[4:2];

  // FrameStart restarts the frame in the same cycle, so its symbol sees index 0
  // and an empty packer regardless of what was held before.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    accept    = QAMDemodDataValid & (FrameStart | (state == COLLECT));
    sym_idx   = FrameStart ? '0 : sym_cnt;
    base_data = FrameStart ? '0 : pack_data;
    base_cnt  = FrameStart ? '0 : pack_cnt;
    is_last   = (sym_idx == LAST_IDX);
    payload   = accept & ~(PILOT_EN && (sym_idx == PILOT_POS));

    merged = {2'b00, base_data};
    if (payload) merged[{base_cnt, 1'b0} +: 2] = QAMDemodData[1:0];

    push      = accept & ((payload & (base_cnt == 2'd3)) |
                          (is_last & (payload | (base_cnt != 2'd0))));
    push_last = accept & is_last;

    pack_data_nxt = base_data;
    pack_cnt_nxt  = base_cnt;
    if (push) begin
      pack_data_nxt = '0;
      pack_cnt_nxt  = '0;
    end else if (payload) begin
      pack_data_nxt = merged[5:0];
      pack_cnt_nxt  = base_cnt + 2'd1;
    end

    sym_cnt_nxt = sym_cnt;
    if (accept)          sym_cnt_nxt = is_last ? '0 : sym_idx + CNT_W'(1);
    else if (FrameStart) sym_cnt_nxt = '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (FrameStart) state_nxt = COLLECT;
      COLLECT: if (!FrameStart && accept && is_last) state_nxt = DRAIN;
      DRAIN:   if (FrameStart) state_nxt = COLLECT;
               else if (pop && ByteLast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop        = ByteValid & ByteReady;
  assign wr_en      = push & (~fifo_full | pop);
  assign head       = mem[rd_ptr[PTR_W-1:0]];
  assign ByteValid  = ~fifo_empty;
  assign ByteData   = ByteValid ? head[7:0] : 8'h00;
  assign ByteLast   = ByteValid & head[8];
  assign Busy       = (state != IDLE);

  // NOTE: the FIFO storage has no reset; output gating on ByteValid hides stale entries.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= {push_last, merged};
  end

  // NOTE: state registers use non-blocking assignments so all update on the same edge.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      sym_cnt    <= '0;
      pack_data  <= '0;
      pack_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Overflow   <= 1'b0;
      FrameDone  <= 1'b0;
      FrameAbort <= 1'b0;
    end else begin
      state      <= state_nxt;
      sym_cnt    <= sym_cnt_nxt;
      pack_data  <= pack_data_nxt;
      pack_cnt   <= pack_cnt_nxt;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && fifo_full && !pop) Overflow <= 1'b1;
      FrameDone  <= pop & ByteLast;
      FrameAbort <= FrameStart & (state == COLLECT);
    end
  end
endmodule

// File: tb/tb_qam4_frame_pack_ctrl.sv
// Directed bench for qam4_frame_pack_ctrl: default 64-symbol instance plus a
// 16-symbol, no-pilot instance; expected bytes are hand-computed constants.
module tb_qam4_frame_pack_ctrl;
  logic       Clk = 1'b0;
  logic       Rst;
  logic       FrameStart, QAMDemodDataValid, ByteReady;
  logic [4:0] QAMDemodData;
  logic       ByteValid, ByteLast, FrameDone, FrameAbort, Overflow, Busy;
  logic [7:0] ByteData;

  logic       fs16, vld16, rdy16;
  logic [4:0] dat16;
  logic       bv16, bl16, fd16, fa16, ov16, busy16;
  logic [7:0] bd16;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic [8:0] pops[$];
  int         pop_cyc[$];
  logic [8:0] exp_q[$];

  always #5 Clk = ~Clk;

  qam4_frame_pack_ctrl u_dut (
    .Clk(Clk), .Rst(Rst), .FrameStart(FrameStart),
    .QAMDemodDataValid(QAMDemodDataValid), .QAMDemodData(QAMDemodData),
    .ByteValid(ByteValid), .ByteData(ByteData), .ByteLast(ByteLast),
    .ByteReady(ByteReady), .FrameDone(FrameDone), .FrameAbort(FrameAbort),
    .Overflow(Overflow), .Busy(Busy)
  );

  qam4_frame_pack_ctrl #(.SYMS_PER_FRAME(16), .PILOT_EN(1'b0), .PILOT_IDX(0)) u_dut16 (
    .Clk(Clk), .Rst(Rst), .FrameStart(fs16),
    .QAMDemodDataValid(vld16), .QAMDemodData(dat16),
    .ByteValid(bv16), .ByteData(bd16), .ByteLast(bl16),
    .ByteReady(rdy16), .FrameDone(fd16), .FrameAbort(fa16),
    .Overflow(ov16), .Busy(busy16)
  );

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (ByteValid && ByteReady) begin
      pops.push_back({ByteLast, ByteData});
      pop_cyc.push_back(cyc);
    end
    if (FrameDone) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic fs, input logic v, input logic [1:0] s);
    FrameStart = fs; QAMDemodDataValid = v; QAMDemodData = {3'b101, s};
    @(posedge Clk); #1;
    FrameStart = 1'b0; QAMDemodDataValid = 1'b0; QAMDemodData = '0;
  endtask

  task automatic send16(input logic fs, input logic v, input logic [1:0] s);
    fs16 = fs; vld16 = v; dat16 = {3'b011, s};
    @(posedge Clk); #1;
    fs16 = 1'b0; vld16 = 1'b0; dat16 = '0;
  endtask

  // Syms i%4 pack to 0xE4 until the pilot at index 36 (a 0) is dropped; after it
  // every byte starts on sym 1: 1 | 2<<2 | 3<<4 | 0<<6 = 0x39. The final byte holds
  // syms 1,2,3 with [7:6]=0, which is also 0x39.
  task automatic add_default_frame();
    for (int i = 0; i < 9; i++) exp_q.push_back({1'b0, 8'hE4});
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 8'h39});
    exp_q.push_back({1'b1, 8'h39});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ByteValid"},  ByteValid,  0);
    check({tag, " ByteData"},   ByteData,   0);
    check({tag, " ByteLast"},   ByteLast,   0);
    check({tag, " FrameDone"},  FrameDone,  0);
    check({tag, " FrameAbort"}, FrameAbort, 0);
    check({tag, " Overflow"},   Overflow,   0);
    check({tag, " Busy"},       Busy,       0);
  endtask

  task automatic wait_done_and_compare(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge Clk);
      if (FrameDone) begin
        seen = 1'b1;
        check({tag, " Busy at FrameDone"}, Busy, 0);
        if (pop_cyc.size() > 0)
          check({tag, " FrameDone latency"}, cyc, pop_cyc[$] + 1);
      end
    end
    check({tag, " FrameDone seen"}, seen, 1);
    @(negedge Clk);
    check({tag, " FrameDone one cycle"}, FrameDone, 0);
    check({tag, " byte count"}, pops.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < pops.size(); i++)
      check($sformatf("%s byte %0d", tag, i), pops[i], exp_q[i]);
  endtask

  initial begin
    int dc0;
    Rst = 1'b1;
    FrameStart = 1'b0; QAMDemodDataValid = 1'b0; QAMDemodData = '0; ByteReady = 1'b0;
    fs16 = 1'b0; vld16 = 1'b0; dat16 = '0; rdy16 = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check_all_zero("reset");
    Rst = 1'b0;

    // Symbols in IDLE are ignored.
    for (int i = 0; i < 3; i++) send(1'b0, 1'b1, 2'(i + 1));
    check("idle ignore Busy", Busy, 0);
    check("idle ignore ByteValid", ByteValid, 0);

    // FrameStart coincident with sym 3 makes it index 0: 3|1<<2|2<<4|3<<6 = 0xE7.
    send(1'b1, 1'b1, 2'd3);
    check("start Busy", Busy, 1);
    send(1'b0, 1'b1, 2'd1);
    send(1'b0, 1'b1, 2'd2);
    check("pre-byte ByteValid", ByteValid, 0);
    send(1'b0, 1'b1, 2'd3);
    check("first byte ByteValid", ByteValid, 1);
    check("first byte ByteData", ByteData, 8'hE7);
    check("first byte ByteLast", ByteLast, 0);
    for (int i = 4; i < 10; i++) send(1'b0, 1'b1, 2'(i % 4));

    // Abort after 10 symbols: 2 full bytes stay, the 2-symbol partial is dropped.
    send(1'b1, 1'b0, 2'd0);
    check("abort FrameAbort", FrameAbort, 1);
    check("abort Busy", Busy, 1);
    check("abort head kept", ByteData, 8'hE7);
    pops.delete(); pop_cyc.delete(); exp_q.delete();
    ByteReady = 1'b1;
    exp_q.push_back({1'b0, 8'hE7});
    exp_q.push_back({1'b0, 8'hE4});
    add_default_frame();
    for (int i = 0; i < 64; i++) begin
      send(1'b0, 1'b1, 2'(i % 4));
      if (i == 0) check("abort pulse width", FrameAbort, 0);
    end
    wait_done_and_compare("after abort");

    // Overflow: sink stalled for a whole frame.
    pops.delete(); pop_cyc.delete();
    ByteReady = 1'b0;
    dc0 = done_cnt;
    send(1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 64; i++) begin
      send(1'b0, 1'b1, 2'(i % 4));
      if (i == 31) check("ovf before 9th push", Overflow, 0);
      if (i == 35) check("ovf on 9th push", Overflow, 1);
    end
    check("ovf Busy in drain", Busy, 1);
    ByteReady = 1'b1;
    repeat (12) @(posedge Clk);
    #1;
    check("ovf drained count", pops.size(), 8);
    for (int i = 0; i < 8 && i < pops.size(); i++)
      check($sformatf("ovf byte %0d", i), pops[i], {1'b0, 8'hE4});
    check("ovf no FrameDone", done_cnt, dc0);
    check("ovf sticky", Overflow, 1);
    check("ovf fifo empty", ByteValid, 0);

    // Reset in the middle of a frame with bytes queued.
    ByteReady = 1'b0;
    send(1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 20; i++) send(1'b0, 1'b1, 2'(i % 4));
    check("pre-reset ByteValid", ByteValid, 1);
    #2 Rst = 1'b1;
    #1 check_all_zero("mid-frame reset");
    @(negedge Clk) Rst = 1'b0;

    // Full default frame after reset, sink always ready.
    pops.delete(); pop_cyc.delete(); exp_q.delete();
    ByteReady = 1'b1;
    add_default_frame();
    send(1'b1, 1'b1, 2'd0);
    for (int i = 1; i < 64; i++) send(1'b0, 1'b1, 2'(i % 4));
    wait_done_and_compare("default frame");
    check("default frame Overflow", Overflow, 0);

    // 16 symbols, no pilot: exactly 4 bytes of 0xE4, Last on the 4th.
    send16(1'b1, 1'b1, 2'd0);
    for (int i = 1; i < 16; i++) send16(1'b0, 1'b1, 2'(i % 4));
    check("s16 Busy in drain", busy16, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("s16 valid %0d", k), bv16, 1);
      check($sformatf("s16 data %0d", k), bd16, 8'hE4);
      check($sformatf("s16 last %0d", k), bl16, (k == 3) ? 1 : 0);
      rdy16 = 1'b1;
      @(posedge Clk); #1;
      rdy16 = 1'b0;
    end
    check("s16 FrameDone", fd16, 1);
    check("s16 empty", bv16, 0);
    check("s16 Busy", busy16, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
